ped_crossing_ctrl: RTL and testbench

//  Demand-driven sequencer for the pedestrian-crossing lights (ROAD_*/PED_* lamps).

---
 rtl/ped_crossing_ctrl_pkg.sv | 30 +++
 rtl/ped_crossing_ctrl_tick_gen.sv | 27 ++
 rtl/ped_crossing_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_ped_crossing_ctrl.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/ped_crossing_ctrl_pkg.sv
// Shared definitions for the pedestrian crossing controller.
// Covers state codes, lamp-vector bit positions and the phase timer width.
package ped_crossing_ctrl_pkg;

  localparam int TIMER_W = 8;

  typedef logic [2:0] state_t;

  localparam state_t ST_ROAD_GO    = 3'd0;
  localparam state_t ST_ROAD_WARN  = 3'd1;
  localparam state_t ST_ALL_RED_1  = 3'd2;
  localparam state_t ST_PED_GO     = 3'd3;
  localparam state_t ST_PED_FLASH  = 3'd4;
  localparam state_t ST_ALL_RED_2  = 3'd5;
  localparam state_t ST_ROAD_READY = 3'd6;

  localparam int L_ROAD_RED    = 0;
  localparam int L_ROAD_YELLOW = 1;
  localparam int L_ROAD_GREEN  = 2;
  localparam int L_PED_RED     = 3;
  localparam int L_PED_GREEN   = 4;
  localparam int L_WAIT        = 5;
  localparam int N_LAMPS       = 6;

  // A phase of N ticks loads N-1, so it expires on the tick that sees zero.
  function automatic logic [TIMER_W-1:0] ticks_to_load(input int ticks);
    return TIMER_W'(ticks - 1);
  endfunction

endpackage

// File: rtl/ped_crossing_ctrl_tick_gen.sv
// Timing-tick prescaler: counts 0..DIV-1 and pulses tick for one cycle at DIV-1.
// DIV must be at least 2.
module ped_crossing_ctrl_tick_gen #(
  parameter int DIV = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt;

  assign tick = (cnt == CW'(DIV - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/ped_crossing_ctrl.sv
// Demand-driven pedestrian crossing sequencer: road-stop -> ped-go -> road-resume on tick timing.
// Define PED_FLASH_EN to add the flashing ped-green phase; otherwise ped-green stays steady for both intervals.
module ped_crossing_ctrl
  import ped_crossing_ctrl_pkg::*;
#(
  parameter int TICK_DIV     = 50_000_000,
  parameter int T_MIN_GREEN  = 10,
  parameter int T_YELLOW     = 3,
  parameter int T_ALL_RED    = 2,
  parameter int T_PED_GREEN  = 8,
  parameter int T_PED_FLASH  = 4,
  parameter int T_RED_YELLOW = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_a,
  input  logic btn_b,
  output logic ROAD_RED,
  output logic ROAD_YELLOW,
  output logic ROAD_GREEN,
  output logic PED_RED,
  output logic PED_GREEN,
  output logic WAIT_LAMP
);

  localparam logic [TIMER_W-1:0] LD_MIN_GREEN  = ticks_to_load(T_MIN_GREEN);
  localparam logic [TIMER_W-1:0] LD_YELLOW     = ticks_to_load(T_YELLOW);
  localparam logic [TIMER_W-1:0] LD_ALL_RED    = ticks_to_load(T_ALL_RED);
  localparam logic [TIMER_W-1:0] LD_RED_YELLOW = ticks_to_load(T_RED_YELLOW);
`ifdef PED_FLASH_EN
  localparam logic [TIMER_W-1:0] LD_PED_GO     = ticks_to_load(T_PED_GREEN);
  localparam logic [TIMER_W-1:0] LD_PED_FLASH  = ticks_to_load(T_PED_FLASH);
`else
  // Steady ped-green spans both intervals; their sum must fit the timer range.
  localparam logic [TIMER_W-1:0] LD_PED_GO     = ticks_to_load(T_PED_GREEN + T_PED_FLASH);
`endif

  logic               tick;
  state_t             state;
  state_t             nstate;
  logic [TIMER_W-1:0] timer;
  logic [TIMER_W-1:0] ld_val;
  logic               expire;
  logic               enter;
  logic               in_ped;
  logic [1:0]         sync_a;
  logic [1:0]         sync_b;
  logic               btn_q;
  logic               btn_d;
  logic               btn_rise;
  logic               req;
  logic [N_LAMPS-1:0] lamps;
`ifdef PED_FLASH_EN
  logic               flash;
`endif

  ped_crossing_ctrl_tick_gen #(
    .DIV (TICK_DIV)
  ) tick_gen (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  assign expire = tick && (timer == '0);
  assign enter  = (nstate != state);
  assign in_ped = (state == ST_PED_GO) || (state == ST_PED_FLASH);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_ALL_RED_2;
    end else begin
      state <= nstate;
    end
  end

  always_comb begin
    nstate = state;
    if (expire) begin
      case (state)
        ST_ROAD_GO:    if (req) nstate = ST_ROAD_WARN;
        ST_ROAD_WARN:  nstate = ST_ALL_RED_1;
        ST_ALL_RED_1:  nstate = ST_PED_GO;
`ifdef PED_FLASH_EN
        ST_PED_GO:     nstate = ST_PED_FLASH;
        ST_PED_FLASH:  nstate = ST_ALL_RED_2;
`else
        ST_PED_GO:     nstate = ST_ALL_RED_2;
`endif
        ST_ALL_RED_2:  nstate = ST_ROAD_READY;
        ST_ROAD_READY: nstate = ST_ROAD_GO;
        default:       nstate = ST_ALL_RED_2;
      endcase
    end
  end

  always_comb begin
    ld_val = LD_ALL_RED;
    case (nstate)
      ST_ROAD_GO:    ld_val = LD_MIN_GREEN;
      ST_ROAD_WARN:  ld_val = LD_YELLOW;
      ST_PED_GO:     ld_val = LD_PED_GO;
`ifdef PED_FLASH_EN
      ST_PED_FLASH:  ld_val = LD_PED_FLASH;
`endif
      ST_ROAD_READY: ld_val = LD_RED_YELLOW;
      default:       ld_val = LD_ALL_RED;
    endcase
  end

  // Saturating at zero lets road-green wait indefinitely for demand.
  always_ff @(posedge clk) begin
    if (rst) begin
      timer <= LD_ALL_RED;
    end else if (enter) begin
      timer <= ld_val;
    end else if (tick && (timer != '0)) begin
      timer <= timer - 1'b1;
    end
  end

`ifdef PED_FLASH_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      flash <= 1'b0;
    end else if (enter && (nstate == ST_PED_FLASH)) begin
      flash <= 1'b1;
    end else if ((state == ST_PED_FLASH) && tick) begin
      flash <= ~flash;
    end
  end
`endif

  // Buttons are synchronised separately, merged, then edge-detected so a held press counts once.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_a <= '0;
      sync_b <= '0;
      btn_q  <= 1'b0;
      btn_d  <= 1'b0;
    end else begin
      sync_a <= {sync_a[0], btn_a};
      sync_b <= {sync_b[0], btn_b};
      btn_q  <= sync_a[1] | sync_b[1];
      btn_d  <= btn_q;
    end
  end

  assign btn_rise = btn_q & ~btn_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      req <= 1'b0;
    end else if (enter && (nstate == ST_PED_GO)) begin
      req <= 1'b0;
    end else if (btn_rise && !in_ped) begin
      req <= 1'b1;
    end
  end

  always_comb begin
    lamps = '0;
    case (state)
      ST_ROAD_GO: begin
        lamps[L_ROAD_GREEN] = 1'b1;
        lamps[L_PED_RED]    = 1'b1;
      end
      ST_ROAD_WARN: begin
        lamps[L_ROAD_YELLOW] = 1'b1;
        lamps[L_PED_RED]     = 1'b1;
      end
      ST_PED_GO: begin
        lamps[L_ROAD_RED]  = 1'b1;
        lamps[L_PED_GREEN] = 1'b1;
      end
`ifdef PED_FLASH_EN
      ST_PED_FLASH: begin
        lamps[L_ROAD_RED]  = 1'b1;
        lamps[L_PED_GREEN] = flash;
      end
`endif
      ST_ROAD_READY: begin
        lamps[L_ROAD_RED]    = 1'b1;
        lamps[L_ROAD_YELLOW] = 1'b1;
        lamps[L_PED_RED]     = 1'b1;
      end
      default: begin
        lamps[L_ROAD_RED] = 1'b1;
        lamps[L_PED_RED]  = 1'b1;
      end
    endcase
    lamps[L_WAIT] = req;
  end

  assign ROAD_RED    = lamps[L_ROAD_RED];
  assign ROAD_YELLOW = lamps[L_ROAD_YELLOW];
  assign ROAD_GREEN  = lamps[L_ROAD_GREEN];
  assign PED_RED     = lamps[L_PED_RED];
  assign PED_GREEN   = lamps[L_PED_GREEN];
  assign WAIT_LAMP   = lamps[L_WAIT];

endmodule

// File: tb/tb_ped_crossing_ctrl.sv
// Bench for ped_crossing_ctrl: directed crossing scenarios plus random button traffic against a phase/tick model.
module tb_ped_crossing_ctrl;

  localparam int TICK_DIV     = 4;
  localparam int T_MIN_GREEN  = 5;
  localparam int T_YELLOW     = 2;
  localparam int T_ALL_RED    = 1;
  localparam int T_PED_GREEN  = 3;
  localparam int T_PED_FLASH  = 2;
  localparam int T_RED_YELLOW = 1;
`ifdef PED_FLASH_EN
  localparam bit FLASH_EN = 1'b1;
`else
  localparam bit FLASH_EN = 1'b0;
`endif
  // Ped-green lit cycles in one crossing: 12 steady + 4 flash-on, or 20 steady.
  localparam int PG_CYC = FLASH_EN ? 16 : 20;

  logic clk = 1'b0;
  logic rst;
  logic btn_a;
  logic btn_b;
  logic ROAD_RED, ROAD_YELLOW, ROAD_GREEN, PED_RED, PED_GREEN, WAIT_LAMP;

  ped_crossing_ctrl #(
    .TICK_DIV(TICK_DIV), .T_MIN_GREEN(T_MIN_GREEN), .T_YELLOW(T_YELLOW),
    .T_ALL_RED(T_ALL_RED), .T_PED_GREEN(T_PED_GREEN), .T_PED_FLASH(T_PED_FLASH),
    .T_RED_YELLOW(T_RED_YELLOW)
  ) dut (
    .clk(clk), .rst(rst), .btn_a(btn_a), .btn_b(btn_b),
    .ROAD_RED(ROAD_RED), .ROAD_YELLOW(ROAD_YELLOW), .ROAD_GREEN(ROAD_GREEN),
    .PED_RED(PED_RED), .PED_GREEN(PED_GREEN), .WAIT_LAMP(WAIT_LAMP)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;

  task automatic chk_eq(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference model: phase, ticks completed in it, free-running cycle count, button history.
  typedef enum int {P_GO, P_WARN, P_AR1, P_PED, P_FLASH, P_AR2, P_READY} phase_e;
  phase_e   m_ph;
  int       m_ticks;
  int       m_elapsed;
  bit       m_req;
  bit [3:0] m_hist;

  function automatic int dur(input phase_e p);
    case (p)
      P_GO:    return T_MIN_GREEN;
      P_WARN:  return T_YELLOW;
      P_PED:   return FLASH_EN ? T_PED_GREEN : T_PED_GREEN + T_PED_FLASH;
      P_FLASH: return T_PED_FLASH;
      P_READY: return T_RED_YELLOW;
      default: return T_ALL_RED;
    endcase
  endfunction

  function automatic phase_e succ(input phase_e p);
    case (p)
      P_GO:    return P_WARN;
      P_WARN:  return P_AR1;
      P_AR1:   return P_PED;
      P_PED:   return FLASH_EN ? P_FLASH : P_AR2;
      P_FLASH: return P_AR2;
      P_AR2:   return P_READY;
      default: return P_GO;
    endcase
  endfunction

  task automatic model_step();
    bit b, rise, tick, leave;
    if (rst) begin
      m_ph = P_AR2; m_ticks = 0; m_elapsed = 0; m_req = 1'b0; m_hist = '0;
      return;
    end
    b      = btn_a | btn_b;
    rise   = m_hist[2] & ~m_hist[3];   // press seen three edges ago, released four ago
    m_hist = {m_hist[2:0], b};
    tick   = (m_elapsed % TICK_DIV) == TICK_DIV - 1;
    m_elapsed++;
    leave  = tick && (m_ticks + 1 >= dur(m_ph)) && (m_ph != P_GO || m_req);
    if (rise && m_ph != P_PED && m_ph != P_FLASH) m_req = 1'b1;
    if (leave) begin
      m_ph = succ(m_ph);
      m_ticks = 0;
      if (m_ph == P_PED) m_req = 1'b0;
    end else if (tick) begin
      m_ticks++;
    end
  endtask

  // Lamp order {ROAD_RED, ROAD_YELLOW, ROAD_GREEN, PED_RED, PED_GREEN, WAIT_LAMP}.
  function automatic logic [5:0] model_lamps();
    logic [4:0] l;
    case (m_ph)
      P_GO:    l = 5'b00110;
      P_WARN:  l = 5'b01010;
      P_PED:   l = 5'b10001;
      P_FLASH: l = {4'b1000, (m_ticks % 2) == 0};
      P_READY: l = 5'b11010;
      default: l = 5'b10010;
    endcase
    return {l, m_req};
  endfunction

  function automatic logic [5:0] dut_lamps();
    return {ROAD_RED, ROAD_YELLOW, ROAD_GREEN, PED_RED, PED_GREEN, WAIT_LAMP};
  endfunction

  int cnt_rg, cnt_ry, cnt_pg, cnt_rr, cnt_pr_off, cnt_wait;
  int pg_rises, wait_rises, first_wait, first_ry;
  bit p_wait, p_ry, p_pg;

  task automatic clr_stats();
    cnt_rg = 0; cnt_ry = 0; cnt_pg = 0; cnt_rr = 0; cnt_pr_off = 0; cnt_wait = 0;
    pg_rises = 0; wait_rises = 0; first_wait = -1; first_ry = -1;
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    cyc++;
    chk_eq("lamps", int'(dut_lamps()), int'(model_lamps()));
    chk_eq("excl_greens", int'(ROAD_GREEN & PED_GREEN), 0);
    chk_eq("pg_without_rr", int'(PED_GREEN & ~ROAD_RED), 0);
    cnt_rg     += int'(ROAD_GREEN);
    cnt_ry     += int'(ROAD_YELLOW);
    cnt_pg     += int'(PED_GREEN);
    cnt_rr     += int'(ROAD_RED);
    cnt_pr_off += int'(!PED_RED);
    cnt_wait   += int'(WAIT_LAMP);
    if (PED_GREEN && !p_pg) pg_rises++;
    if (WAIT_LAMP && !p_wait) begin
      wait_rises++;
      if (first_wait < 0) first_wait = cyc;
    end
    if (ROAD_YELLOW && !p_ry && first_ry < 0) first_ry = cyc;
    p_pg = PED_GREEN; p_wait = WAIT_LAMP; p_ry = ROAD_YELLOW;
  endtask

  // Buttons are driven per edge number: high while the upcoming edge lies in [lo, hi].
  task automatic run(input int upto, input int a_lo, input int a_hi, input int b_lo, input int b_hi);
    while (cyc < upto) begin
      btn_a = (cyc + 1 >= a_lo) && (cyc + 1 <= a_hi);
      btn_b = (cyc + 1 >= b_lo) && (cyc + 1 <= b_hi);
      cycle();
    end
  endtask

  initial begin
    int  press_left;
    int  which;
    rst = 1'b1; btn_a = 1'b0; btn_b = 1'b0;
    p_wait = 1'b0; p_ry = 1'b0; p_pg = 1'b0;
    repeat (3) cycle();
    chk_eq("rst_lamps", int'(dut_lamps()), int'(6'b100100));

    // Power-up sequence and one crossing from an early press.
    rst = 1'b0; cyc = 0; clr_stats();
    run(12, 10, 11, 0, -1);
    chk_eq("s2_wait_pre", int'(WAIT_LAMP), 0);
    run(13, 10, 11, 0, -1);
    chk_eq("s2_wait_set", int'(WAIT_LAMP), 1);
    run(80, 10, 11, 0, -1);
    chk_eq("s2_road_green_cyc", cnt_rg, 33);
    chk_eq("s2_road_yellow_cyc", cnt_ry, 16);
    chk_eq("s2_ped_green_cyc", cnt_pg, PG_CYC);
    chk_eq("s2_road_red_cyc", cnt_rr, 39);
    chk_eq("s2_ped_red_off_cyc", cnt_pr_off, 20);
    chk_eq("s2_wait_cyc", cnt_wait, 27);

    // Late press: yellow on the first tick after the request latches.
    clr_stats();
    run(200, 0, -1, 168, 169);
    chk_eq("s3_wait_edge", first_wait, 171);
    chk_eq("s3_yellow_edge", first_ry, 172);
    run(230, 0, -1, 0, -1);

    // Long hold gives one crossing only.
    clr_stats();
    run(520, 240, 439, 0, -1);
    chk_eq("s4_hold_ped_rises", pg_rises, 1);
    chk_eq("s4_hold_wait_rises", wait_rises, 1);

    // Press during ped-go is dropped.
    clr_stats();
    run(600, 530, 531, 552, 553);
    chk_eq("s4_pedgo_ped_rises", pg_rises, 1);
    chk_eq("s4_pedgo_wait_rises", wait_rises, 1);

    // Reset in the middle of ped-go.
    run(719, 700, 701, 0, -1);
    chk_eq("s5_ped_green_pre", int'(PED_GREEN), 1);
    rst = 1'b1;
    run(720, 0, -1, 0, -1);
    chk_eq("s5_rst_lamps", int'(dut_lamps()), int'(6'b100100));
    rst = 1'b0;

    // Random traffic on both buttons with rare resets.
    press_left = 0; which = 0;
    for (int k = 0; k < 3000; k++) begin
      if (press_left == 0 && $urandom_range(0, 39) == 0) begin
        press_left = $urandom_range(1, 30);
        which = $urandom_range(0, 2);
      end
      btn_a = (press_left > 0) && (which != 1);
      btn_b = (press_left > 0) && (which != 0);
      if (press_left > 0) press_left--;
      rst = ($urandom_range(0, 999) == 0);
      cycle();
    end
    rst = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
